// File: rtl/dfi_stub_pkg.sv
// Shared definitions for the DFI PHY responder stub: bus widths, command codes, phyupd states.
package dfi_stub_pkg;

  localparam int unsigned DfiAddrW = 16;
  localparam int unsigned DfiBankW = 3;
  localparam int unsigned DfiCsW   = 4;
  localparam int unsigned DfiEnW   = 4;
  localparam int unsigned DfiDataW = 64;
  localparam int unsigned DfiMaskW = DfiDataW / 8;

  // Command codes on {ras_n, cas_n, we_n}
  localparam logic [2:0] CmdWrite = 3'b100;
  localparam logic [2:0] CmdRead  = 3'b101;

  typedef enum logic [1:0] {
    PhyIdle,
    PhyReq,
    PhyHold
  } phyupd_state_e;

  // Overlay the bytes of new_data whose mask bit is 0 onto old_data.
  function automatic logic [DfiDataW-1:0] merge_bytes(input logic [DfiDataW-1:0] old_data,
                                                      input logic [DfiDataW-1:0] new_data,
                                                      input logic [DfiMaskW-1:0] mask);
    logic [DfiDataW-1:0] res;
    res = old_data;
    for (int b = 0; b < int'(DfiMaskW); b++) begin
      if (!mask[b]) res[b*8 +: 8] = new_data[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dfi_stub_fifo.sv
// Small synchronous FIFO holding command indices until the matching data enable arrives.
// Depth must be a power of two so the pointers wrap naturally.
module dfi_stub_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q;
  logic [PtrW-1:0]  rptr_q;
  logic [PtrW:0]    cnt_q;
  logic             pop_ok;
  logic             push_ok;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (PtrW + 1)'(Depth));
  assign rdata_o = mem_q[rptr_q];

  // Pop is resolved first, so a full FIFO accepts a push in the same cycle as a pop,
  // while a pop on an empty FIFO is dropped and a simultaneous push is still kept.
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + PtrW'(1);
      if (pop_ok)  rptr_q <= rptr_q + PtrW'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + (PtrW + 1)'(1);
        2'b01:   cnt_q <= cnt_q - (PtrW + 1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Entry storage; contents are meaningless while unoccupied, so no reset.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/dfi_phy_stub.sv
// PHY-side DFI responder: queues WRITE/READ command indices, services data enables against a
// byte-masked data store, returns read data after a fixed latency and runs the init and
// ctrlupd/phyupd handshakes.
module dfi_phy_stub
  import dfi_stub_pkg::*;
#(
  parameter int unsigned RDLAT         = 4,
  parameter int unsigned INIT_CYCLES   = 16,
  parameter int unsigned PHYUPD_PERIOD = 256,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned MEM_AW        = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [DfiAddrW-1:0] dfi_address,
  input  logic [DfiBankW-1:0] dfi_bank,
  input  logic [DfiCsW-1:0]   dfi_cs_n,
  input  logic                dfi_ras_n,
  input  logic                dfi_cas_n,
  input  logic                dfi_we_n,
  input  logic [DfiEnW-1:0]   dfi_wrdata_en,
  input  logic [DfiDataW-1:0] dfi_wrdata,
  input  logic [DfiMaskW-1:0] dfi_wrdata_mask,
  input  logic [DfiEnW-1:0]   dfi_rddata_en,
  output logic [DfiDataW-1:0] dfi_rddata,
  output logic                dfi_rddata_valid,
  input  logic                dfi_ctrlupd_req,
  output logic                dfi_ctrlupd_ack,
  output logic                dfi_phyupd_req,
  output logic [1:0]          dfi_phyupd_type,
  input  logic                dfi_phyupd_ack,
  output logic                dfi_init_complete,
  output logic                err_overflow,
  output logic                err_underflow
);

  localparam int unsigned ColW    = MEM_AW - 3;
  localparam int unsigned Entries = 2 ** MEM_AW;
  localparam int unsigned InitW   = $clog2(INIT_CYCLES + 1);
  localparam int unsigned PerW    = (PHYUPD_PERIOD > 1) ? $clog2(PHYUPD_PERIOD) : 1;

  // ---------------------------------------------------------------------------------------------
  // Init sequencing
  // ---------------------------------------------------------------------------------------------
  logic [InitW-1:0] init_cnt_q;
  logic             init_done_q;

  // Count edges after reset release; init_complete rises on edge INIT_CYCLES and sticks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
    end else if (!init_done_q) begin
      init_cnt_q <= init_cnt_q + InitW'(1);
      if (init_cnt_q == InitW'(INIT_CYCLES - 1)) init_done_q <= 1'b1;
    end
  end

  assign dfi_init_complete = init_done_q;

  // ---------------------------------------------------------------------------------------------
  // Command decode and index FIFOs
  // ---------------------------------------------------------------------------------------------
  logic              cmd_vld;
  logic [2:0]        cmd;
  logic [MEM_AW-1:0] cmd_idx;
  logic              wr_push;
  logic              rd_push;

  assign cmd_vld = !(&dfi_cs_n) && init_done_q;
  assign cmd     = {dfi_ras_n, dfi_cas_n, dfi_we_n};
  assign cmd_idx = {dfi_bank, dfi_address[ColW-1:0]};
  assign wr_push = cmd_vld && (cmd == CmdWrite);
  assign rd_push = cmd_vld && (cmd == CmdRead);

  logic              wf_full;
  logic              wf_empty;
  logic [MEM_AW-1:0] wf_idx;
  logic              rf_full;
  logic              rf_empty;
  logic [MEM_AW-1:0] rf_idx;

  dfi_stub_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (MEM_AW)
  ) u_wr_fifo (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .push_i  (wr_push),
    .wdata_i (cmd_idx),
    .pop_i   (dfi_wrdata_en[0]),
    .rdata_o (wf_idx),
    .full_o  (wf_full),
    .empty_o (wf_empty)
  );

  dfi_stub_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (MEM_AW)
  ) u_rd_fifo (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .push_i  (rd_push),
    .wdata_i (cmd_idx),
    .pop_i   (dfi_rddata_en[0]),
    .rdata_o (rf_idx),
    .full_o  (rf_full),
    .empty_o (rf_empty)
  );

  logic wr_do;
  logic rd_do;
  logic ovf_evt;
  logic unf_evt;

  assign wr_do   = dfi_wrdata_en[0] && !wf_empty;
  assign rd_do   = dfi_rddata_en[0] && !rf_empty;
  // A push into a full FIFO is only lost when no pop frees a slot in the same cycle.
  assign ovf_evt = (wr_push && wf_full && !wr_do) || (rd_push && rf_full && !rd_do);
  assign unf_evt = (dfi_wrdata_en[0] && wf_empty) || (dfi_rddata_en[0] && rf_empty);

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      if (ovf_evt) err_overflow <= 1'b1;
      if (unf_evt) err_underflow <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Data store
  // ---------------------------------------------------------------------------------------------
  logic [DfiDataW-1:0] store_q [Entries];
  logic [Entries-1:0]  written_q;
  logic [DfiDataW-1:0] wr_base;
  logic [DfiDataW-1:0] rd_data;

  // Never-written entries read as zero; masked bytes of a first write stay zero too.
  assign wr_base = written_q[wf_idx] ? store_q[wf_idx] : '0;
  // Read sees the pre-write value when both pops hit the same index in one cycle.
  assign rd_data = written_q[rf_idx] ? store_q[rf_idx] : '0;

  // Written-entry tracking.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      written_q <= '0;
    end else if (wr_do) begin
      written_q[wf_idx] <= 1'b1;
    end
  end

  // Byte-masked store update; contents are qualified by written_q, so no reset.
  always_ff @(posedge clk) begin
    if (wr_do) store_q[wf_idx] <= merge_bytes(wr_base, dfi_wrdata, dfi_wrdata_mask);
  end

  // ---------------------------------------------------------------------------------------------
  // Read latency pipeline
  // ---------------------------------------------------------------------------------------------
  logic [RDLAT-1:0]    pipe_vld_q;
  logic [DfiDataW-1:0] pipe_dat_q [RDLAT];

  // Shift popped read data through RDLAT stages; data is zero in empty slots.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pipe_vld_q <= '0;
      for (int i = 0; i < int'(RDLAT); i++) pipe_dat_q[i] <= '0;
    end else begin
      pipe_vld_q[0] <= rd_do;
      pipe_dat_q[0] <= rd_do ? rd_data : '0;
      for (int i = 1; i < int'(RDLAT); i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        pipe_dat_q[i] <= pipe_dat_q[i-1];
      end
    end
  end

  assign dfi_rddata_valid = pipe_vld_q[RDLAT-1];
  assign dfi_rddata       = pipe_dat_q[RDLAT-1];

  // ---------------------------------------------------------------------------------------------
  // Update handshakes
  // ---------------------------------------------------------------------------------------------
  logic ctrlupd_ack_q;

  // ctrlupd ack simply follows the request one cycle later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrlupd_ack_q <= 1'b0;
    end else begin
      ctrlupd_ack_q <= dfi_ctrlupd_req;
    end
  end

  assign dfi_ctrlupd_ack = ctrlupd_ack_q;

  phyupd_state_e  phy_state_q;
  logic [PerW-1:0] phy_cnt_q;
  logic            phy_hold_q;
  logic            phyupd_req_q;

  // phyupd FSM: count the period after init, request, wait for ack, hold two cycles, repeat.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phy_state_q  <= PhyIdle;
      phy_cnt_q    <= '0;
      phy_hold_q   <= 1'b0;
      phyupd_req_q <= 1'b0;
    end else begin
      unique case (phy_state_q)
        PhyIdle: begin
          if (init_done_q && (PHYUPD_PERIOD != 0)) begin
            if (phy_cnt_q == PerW'(PHYUPD_PERIOD - 1)) begin
              phy_state_q  <= PhyReq;
              phy_cnt_q    <= '0;
              phyupd_req_q <= 1'b1;
            end else begin
              phy_cnt_q <= phy_cnt_q + PerW'(1);
            end
          end
        end
        PhyReq: begin
          if (dfi_phyupd_ack) begin
            phy_state_q <= PhyHold;
            phy_hold_q  <= 1'b0;
          end
        end
        PhyHold: begin
          if (phy_hold_q) begin
            phy_state_q  <= PhyIdle;
            phyupd_req_q <= 1'b0;
          end else begin
            phy_hold_q <= 1'b1;
          end
        end
        default: begin
          phy_state_q  <= PhyIdle;
          phyupd_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign dfi_phyupd_req  = phyupd_req_q;
  assign dfi_phyupd_type = 2'b00;

  // Address bits above the store index and the upper enable phases are not used.
  logic unused_inputs;
  assign unused_inputs = ^{dfi_address[DfiAddrW-1:ColW], dfi_wrdata_en[DfiEnW-1:1],
                           dfi_rddata_en[DfiEnW-1:1]};

endmodule

// File: tb/tb_dfi_phy_stub.sv
// Bench for dfi_phy_stub: directed DFI traffic, read beats checked by a queue-based monitor.
module tb_dfi_phy_stub;

  localparam int unsigned RdLat  = 4;
  localparam int unsigned InitCy = 16;
  localparam int unsigned Period = 256;

  localparam logic [2:0] CWr  = 3'b100;
  localparam logic [2:0] CRd  = 3'b101;
  localparam logic [2:0] CAct = 3'b011;
  localparam logic [2:0] CRef = 3'b001;

  logic        clk;
  logic        reset_n;
  logic [15:0] dfi_address;
  logic [2:0]  dfi_bank;
  logic [3:0]  dfi_cs_n;
  logic        dfi_ras_n;
  logic        dfi_cas_n;
  logic        dfi_we_n;
  logic [3:0]  dfi_wrdata_en;
  logic [63:0] dfi_wrdata;
  logic [7:0]  dfi_wrdata_mask;
  logic [3:0]  dfi_rddata_en;
  logic [63:0] dfi_rddata;
  logic        dfi_rddata_valid;
  logic        dfi_ctrlupd_req;
  logic        dfi_ctrlupd_ack;
  logic        dfi_phyupd_req;
  logic [1:0]  dfi_phyupd_type;
  logic        dfi_phyupd_ack;
  logic        dfi_init_complete;
  logic        err_overflow;
  logic        err_underflow;

  dfi_phy_stub #(
    .RDLAT         (RdLat),
    .INIT_CYCLES   (InitCy),
    .PHYUPD_PERIOD (Period),
    .FIFO_DEPTH    (4),
    .MEM_AW        (8)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .dfi_address       (dfi_address),
    .dfi_bank          (dfi_bank),
    .dfi_cs_n          (dfi_cs_n),
    .dfi_ras_n         (dfi_ras_n),
    .dfi_cas_n         (dfi_cas_n),
    .dfi_we_n          (dfi_we_n),
    .dfi_wrdata_en     (dfi_wrdata_en),
    .dfi_wrdata        (dfi_wrdata),
    .dfi_wrdata_mask   (dfi_wrdata_mask),
    .dfi_rddata_en     (dfi_rddata_en),
    .dfi_rddata        (dfi_rddata),
    .dfi_rddata_valid  (dfi_rddata_valid),
    .dfi_ctrlupd_req   (dfi_ctrlupd_req),
    .dfi_ctrlupd_ack   (dfi_ctrlupd_ack),
    .dfi_phyupd_req    (dfi_phyupd_req),
    .dfi_phyupd_type   (dfi_phyupd_type),
    .dfi_phyupd_ack    (dfi_phyupd_ack),
    .dfi_init_complete (dfi_init_complete),
    .err_overflow      (err_overflow),
    .err_underflow     (err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int          total;
  int          bad;
  logic [63:0] exp_data_q[$];
  int          exp_cyc_q[$];
  logic [3:0]  cmd_cs;
  int          rel;
  int          init_edge;
  logic [63:0] mon_d;
  int          mon_c;

  task automatic chk_bit(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b, required %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_word(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [2:0] c, input logic [2:0] b, input logic [15:0] a);
    dfi_cs_n = cmd_cs;
    {dfi_ras_n, dfi_cas_n, dfi_we_n} = c;
    dfi_bank = b;
    dfi_address = a;
    step();
    dfi_cs_n = 4'hF;
    {dfi_ras_n, dfi_cas_n, dfi_we_n} = 3'b111;
  endtask

  task automatic wr_beat(input logic [63:0] d, input logic [7:0] m);
    dfi_wrdata_en = 4'h1;
    dfi_wrdata = d;
    dfi_wrdata_mask = m;
    step();
    dfi_wrdata_en = 4'h0;
  endtask

  // Beat expected on the bus RdLat cycles after the cycle the enable is driven in.
  task automatic rd_beat(input logic [63:0] exp);
    exp_data_q.push_back(exp);
    exp_cyc_q.push_back(cyc + int'(RdLat));
    dfi_rddata_en = 4'h1;
    step();
    dfi_rddata_en = 4'h0;
  endtask

  task automatic rd_wr_beat(input logic [63:0] wd, input logic [7:0] m, input logic [63:0] exp);
    exp_data_q.push_back(exp);
    exp_cyc_q.push_back(cyc + int'(RdLat));
    dfi_rddata_en = 4'h1;
    dfi_wrdata_en = 4'h1;
    dfi_wrdata = wd;
    dfi_wrdata_mask = m;
    step();
    dfi_rddata_en = 4'h0;
    dfi_wrdata_en = 4'h0;
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      total++;
      if (dfi_rddata_valid === 1'b1) begin
        if (exp_data_q.size() == 0) begin
          bad++;
          $display("FAIL rd_unexpected: got beat %h, required no beat (cycle %0d)", dfi_rddata,
                   cyc);
        end else begin
          mon_d = exp_data_q.pop_front();
          mon_c = exp_cyc_q.pop_front();
          if (dfi_rddata !== mon_d) begin
            bad++;
            $display("FAIL rd_data: got %h, required %h (cycle %0d)", dfi_rddata, mon_d, cyc);
          end
          total++;
          if (cyc != mon_c) begin
            bad++;
            $display("FAIL rd_latency: got cycle %0d, required cycle %0d", cyc, mon_c);
          end
        end
      end else if (dfi_rddata !== 64'd0) begin
        bad++;
        $display("FAIL rd_idle_data: got %h, required 0 (cycle %0d)", dfi_rddata, cyc);
      end
    end
  endtask

  task automatic run_main();
    // Reset state
    repeat (3) step();
    chk_bit("rst_valid", dfi_rddata_valid, 1'b0);
    chk_bit("rst_init", dfi_init_complete, 1'b0);
    chk_bit("rst_ovf", err_overflow, 1'b0);
    chk_bit("rst_unf", err_underflow, 1'b0);
    chk_bit("rst_phyreq", dfi_phyupd_req, 1'b0);
    chk_bit("rst_ctrlack", dfi_ctrlupd_ack, 1'b0);
    reset_n = 1'b1;
    rel = cyc;

    // Commands before init must be ignored; a stray push would misalign the later reads.
    step();
    send_cmd(CWr, 3'd2, 16'h0005);
    send_cmd(CRd, 3'd2, 16'h0005);
    while (cyc < rel + int'(InitCy) - 1) step();
    chk_bit("init_early", dfi_init_complete, 1'b0);
    step();
    chk_bit("init_rise", dfi_init_complete, 1'b1);
    init_edge = cyc;

    // Non-data commands and a deselected WRITE are ignored.
    send_cmd(CAct, 3'd2, 16'h0005);
    send_cmd(CRef, 3'd0, 16'h0000);
    cmd_cs = 4'hF;
    send_cmd(CWr, 3'd2, 16'h0005);
    cmd_cs = 4'b1110;

    // Full write then read back
    send_cmd(CWr, 3'd2, 16'h0005);
    wr_beat(64'hDEADBEEF_01234567, 8'h00);
    send_cmd(CRd, 3'd2, 16'h0005);
    rd_beat(64'hDEADBEEF_01234567);

    // Masked rewrite, then back-to-back reads of it and of a never-written entry
    send_cmd(CWr, 3'd2, 16'h0005);
    wr_beat(64'hFFFFFFFF_FFFFFFFF, 8'h0F);
    send_cmd(CRd, 3'd2, 16'h0005);
    send_cmd(CRd, 3'd3, 16'h0007);
    rd_beat(64'hFFFFFFFF_01234567);
    rd_beat(64'h0);

    // Same-cycle write and read pop to one index: read returns the old data
    send_cmd(CWr, 3'd1, 16'h0002);
    wr_beat(64'h11112222_33334444, 8'h00);
    send_cmd(CWr, 3'd1, 16'h0002);
    send_cmd(CRd, 3'd1, 16'h0002);
    rd_wr_beat(64'hAAAABBBB_CCCCDDDD, 8'h00, 64'h11112222_33334444);
    send_cmd(CRd, 3'd1, 16'h0002);
    rd_beat(64'hAAAABBBB_CCCCDDDD);

    // Only address[4:0] reaches the index: 0x0123 and 0x0003 alias; other cs_n bit selects
    cmd_cs = 4'b0111;
    send_cmd(CWr, 3'd4, 16'h0123);
    wr_beat(64'h0F0F0F0F_A5A5A5A5, 8'h00);
    send_cmd(CRd, 3'd4, 16'h0003);
    rd_beat(64'h0F0F0F0F_A5A5A5A5);
    cmd_cs = 4'b1110;

    repeat (RdLat + 2) step();
    chk_word("rd_drain", 64'(exp_data_q.size()), 64'd0);
    chk_bit("no_ovf_yet", err_overflow, 1'b0);
    chk_bit("no_unf_yet", err_underflow, 1'b0);

    // Overflow on the fifth un-serviced WRITE
    for (int i = 0; i < 4; i++) send_cmd(CWr, 3'd0, 16'(i));
    chk_bit("ovf_at_4", err_overflow, 1'b0);
    send_cmd(CWr, 3'd0, 16'h0004);
    chk_bit("ovf_at_5", err_overflow, 1'b1);

    // Underflow on read enable with nothing queued; the monitor rejects any beat
    dfi_rddata_en = 4'h1;
    step();
    dfi_rddata_en = 4'h0;
    chk_bit("unf_set", err_underflow, 1'b1);
    repeat (RdLat + 2) step();

    // ctrlupd: ack trails req by one cycle, same width
    dfi_ctrlupd_req = 1'b1;
    chk_bit("ctrl_ack_pre", dfi_ctrlupd_ack, 1'b0);
    step();
    chk_bit("ctrl_ack_1", dfi_ctrlupd_ack, 1'b1);
    step();
    chk_bit("ctrl_ack_2", dfi_ctrlupd_ack, 1'b1);
    step();
    chk_bit("ctrl_ack_3", dfi_ctrlupd_ack, 1'b1);
    dfi_ctrlupd_req = 1'b0;
    step();
    chk_bit("ctrl_ack_drop", dfi_ctrlupd_ack, 1'b0);

    // phyupd: request exactly Period edges after init, released two cycles after ack
    total++;
    if (cyc >= init_edge + int'(Period) - 1) begin
      bad++;
      $display("FAIL phy_schedule: got cycle %0d, required below %0d", cyc,
               init_edge + int'(Period) - 1);
    end
    while (cyc < init_edge + int'(Period) - 1) step();
    chk_bit("phy_early", dfi_phyupd_req, 1'b0);
    chk_word("phy_type", 64'(dfi_phyupd_type), 64'd0);
    step();
    chk_bit("phy_rise", dfi_phyupd_req, 1'b1);
    repeat (4) step();
    chk_bit("phy_wait", dfi_phyupd_req, 1'b1);
    dfi_phyupd_ack = 1'b1;
    step();
    dfi_phyupd_ack = 1'b0;
    chk_bit("phy_hold1", dfi_phyupd_req, 1'b1);
    step();
    chk_bit("phy_hold2", dfi_phyupd_req, 1'b1);
    step();
    chk_bit("phy_drop", dfi_phyupd_req, 1'b0);

    // Reset with two reads in flight: no beat may emerge and init restarts
    send_cmd(CRd, 3'd2, 16'h0005);
    send_cmd(CRd, 3'd2, 16'h0005);
    dfi_rddata_en = 4'h1;
    step();
    step();
    dfi_rddata_en = 4'h0;
    chk_bit("err_sticky", err_overflow, 1'b1);
    reset_n = 1'b0;
    repeat (3) step();
    chk_bit("mid_rst_init", dfi_init_complete, 1'b0);
    chk_bit("mid_rst_ovf", err_overflow, 1'b0);
    chk_bit("mid_rst_unf", err_underflow, 1'b0);
    chk_bit("mid_rst_phy", dfi_phyupd_req, 1'b0);
    reset_n = 1'b1;
    rel = cyc;
    while (cyc < rel + int'(InitCy) - 1) step();
    chk_bit("reinit_early", dfi_init_complete, 1'b0);
    step();
    chk_bit("reinit_rise", dfi_init_complete, 1'b1);
    repeat (2) step();
  endtask

  initial begin
    total = 0;
    bad = 0;
    cmd_cs = 4'b1110;
    reset_n = 1'b0;
    dfi_address = '0;
    dfi_bank = '0;
    dfi_cs_n = 4'hF;
    dfi_ras_n = 1'b1;
    dfi_cas_n = 1'b1;
    dfi_we_n = 1'b1;
    dfi_wrdata_en = '0;
    dfi_wrdata = '0;
    dfi_wrdata_mask = '0;
    dfi_rddata_en = '0;
    dfi_ctrlupd_req = 1'b0;
    dfi_phyupd_ack = 1'b0;
    fork
      run_main();
      monitor();
      begin
        #200000;
        total++;
        bad++;
        $display("FAIL timeout: got no end of sequence, required end by cycle %0d", cyc);
      end
    join_any
    disable fork;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dfi_phy_stub.md
# dfi_phy_stub

PHY-side responder for the DFI controller interface: accepts MC commands, write data and read-data enables, and answers with read data, init-complete and update handshakes. It sits in the testbench on the far side of the DFI bus from the memory controller, alongside the passive DFI monitor. It keeps a small byte-masked data store so write-then-read traffic checks end to end.

## Interface
- RDLAT, 4, cycles from accepted dfi_rddata_en to dfi_rddata_valid (>=1)
- INIT_CYCLES, 16, cycles after reset release before dfi_init_complete rises
- PHYUPD_PERIOD, 256, cycles between PHY update requests after init (0 disables)
- FIFO_DEPTH, 4, entries in each of the write-address and read-address FIFOs (power of 2)
- MEM_AW, 8, data-store index width = {bank[2:0], dfi_address[MEM_AW-4:0]}

Ports:
- clk  in  1  single clock, all logic rising-edge
- reset_n  in  1  asynchronous active-low reset
- dfi_address  in  16  row/column address
- dfi_bank  in  3  bank
- dfi_cs_n / dfi_ras_n / dfi_cas_n / dfi_we_n  in  4/1/1/1  command pins
- dfi_wrdata_en  in  4  write-data enable (bit 0 used)
- dfi_wrdata  in  64  write data
- dfi_wrdata_mask  in  8  per-byte mask, 1 = byte not written
- dfi_rddata_en  in  4  read-data enable (bit 0 used)
- dfi_rddata  out  64  read data
- dfi_rddata_valid  out  1  read data valid
- dfi_ctrlupd_req  in  1  MC update request
- dfi_ctrlupd_ack  out  1  MC update acknowledge
- dfi_phyupd_req  out  1  PHY update request
- dfi_phyupd_type  out  2  always 2'b00
- dfi_phyupd_ack  in  1  MC acknowledge of PHY update
- dfi_init_complete  out  1  PHY initialised
- err_overflow  out  1  sticky: command pushed to a full FIFO
- err_underflow  out  1  sticky: data enable with empty FIFO

## Operation
- Reset: all outputs 0; FIFOs empty; RDLAT pipeline cleared; per-entry written bits cleared; init counter restarts. Reset mid-traffic drops everything in flight, no partial beat emitted.
- Command valid when any dfi_cs_n bit is 0 and dfi_init_complete=1. Decode {ras_n,cas_n,we_n}: 3'b100 WRITE, 3'b101 READ; everything else (ACT, PRE, REF, MRS, NOP) ignored. Commands before init_complete ignored.
- WRITE pushes index into write FIFO; READ pushes into read FIFO. One data beat per command.
- dfi_wrdata_en[0]=1: pop write FIFO, write unmasked bytes of dfi_wrdata at popped index, set its written bit. Empty: set err_underflow, no write.
- dfi_rddata_en[0]=1: pop read FIFO, read store (unwritten entry returns 0), enter RDLAT pipeline. Empty: set err_underflow, no beat issued.
- Same-cycle push and pop on a FIFO: pop first; full+pop+push is legal, no overflow. Empty+push+pop: underflow, pushed entry retained.
- Same-cycle write pop and read pop to same index: read returns pre-write data.
- ctrlupd: dfi_ctrlupd_ack goes 1 the cycle after dfi_ctrlupd_req is sampled 1, goes 0 the cycle after req sampled 0.
- phyupd FSM: IDLE (counts PHYUPD_PERIOD after init) -> REQ (req=1, wait ack=1) -> HOLD (2 cycles, req=1) -> IDLE (req=0, counter reloads). Ack held for the whole HOLD is not checked.
- Error flags clear only on reset.

## Timing
- dfi_init_complete rises exactly INIT_CYCLES rising edges after reset_n deasserts; stays 1.
- Read: rddata_en sampled at edge N -> dfi_rddata_valid=1 with data during cycle N+RDLAT; back-to-back enables give back-to-back valid beats. dfi_rddata is 0 when valid=0.
- Write store update visible to a read pop in the following cycle.
- First phyupd_req RDLAT-independent: asserted PHYUPD_PERIOD cycles after init_complete.

## Structure
- Shared package dfi_stub_pkg: command encoding constants, phyupd state enum, DFI widths.
- One sub-module dfi_stub_fifo (parameterised depth/width, push/pop/full/empty), instantiated twice.
- Data store is a flat register array with written-bit vector in the top level.

## Test plan
- Reset release -> init_complete at cycle 16; WRITE before that ignored, no FIFO push.
- WRITE bank 2 addr 0x0005, wrdata_en with 0xDEADBEEF_01234567 mask 0x00; READ same, rddata_en -> valid 4 cycles later, data 0xDEADBEEF_01234567.
- Rewrite with mask 0x0F and data 0xFFFF...; read -> 0xFFFFFFFF_01234567; read unwritten index -> 0.
- Five WRITEs without wrdata_en -> err_overflow=1 on fifth; rddata_en with empty read FIFO -> err_underflow=1, no valid.
- ctrlupd_req held 3 cycles -> ack 1 cycle delayed, 3 cycles wide; phyupd_req at init+256, ack after 5 cycles -> req drops 2 cycles after ack.
- Reset asserted with 2 reads in pipeline -> valid never rises; init restarts from 0.
